// File: rtl/axi2mem_r_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axi2mem_r_fifo
// Description : Multi-entry AXI R-channel beat FIFO with fill reporting and
//               optional store-and-forward release of complete bursts.
// Revision    : 1.0 - initial multi-entry release
// ============================================================================
module axi2mem_r_fifo #(
    parameter int ID_WIDTH     = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int USER_WIDTH   = 6,
    parameter int DEPTH        = 4,
    parameter int STORE_FWD    = 0,
    parameter int AFULL_THRESH = DEPTH - 1,
    parameter int CNT_WIDTH    = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  slave_valid_i,
    input  logic [DATA_WIDTH-1:0] slave_data_i,
    input  logic [1:0]            slave_resp_i,
    input  logic [USER_WIDTH-1:0] slave_user_i,
    input  logic [ID_WIDTH-1:0]   slave_id_i,
    input  logic                  slave_last_i,
    output logic                  slave_ready_o,
    output logic                  master_valid_o,
    output logic [DATA_WIDTH-1:0] master_data_o,
    output logic [1:0]            master_resp_o,
    output logic [USER_WIDTH-1:0] master_user_o,
    output logic [ID_WIDTH-1:0]   master_id_o,
    output logic                  master_last_o,
    input  logic                  master_ready_i,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic [CNT_WIDTH-1:0]  bursts_o,
    output logic                  almost_full_o
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_BEAT_W = ID_WIDTH + USER_WIDTH + DATA_WIDTH + 2 + 1;

    logic [c_BEAT_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W:0]     r_wptr;
    logic [c_PTR_W:0]     r_rptr;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_bursts;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_valid;
    logic [c_BEAT_W-1:0]  w_wr_beat;
    logic [c_BEAT_W-1:0]  w_rd_beat;
    logic [CNT_WIDTH-1:0] w_count_next;
    logic [CNT_WIDTH-1:0] w_bursts_next;

    assign w_full  = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                     (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);
    assign w_empty = (r_wptr == r_rptr);

    assign w_push  = slave_valid_i & ~w_full;
    assign w_pop   = w_valid & master_ready_i;

    assign w_wr_beat = {slave_id_i, slave_user_i, slave_data_i, slave_resp_i, slave_last_i};
    assign w_rd_beat = r_mem[r_rptr[c_PTR_W-1:0]];

    always_comb begin
        w_count_next  = r_count;
        w_bursts_next = r_bursts;
        if (w_push && !w_pop) begin
            w_count_next = r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        if ((w_push && slave_last_i) && !(w_pop && w_rd_beat[0])) begin
            w_bursts_next = r_bursts + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else if ((w_pop && w_rd_beat[0]) && !(w_push && slave_last_i)) begin
            w_bursts_next = r_bursts - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_bursts <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr[c_PTR_W-1:0]] <= w_wr_beat;
                r_wptr <= r_wptr + {{c_PTR_W{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rptr <= r_rptr + {{c_PTR_W{1'b0}}, 1'b1};
            end
            r_count  <= w_count_next;
            r_bursts <= w_bursts_next;
        end
    end

    generate
        if (STORE_FWD != 0) begin : g_store_fwd
            // Release lets an over-long burst drain once it has filled the FIFO.
            logic r_release;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_release <= 1'b0;
                end else if ((w_pop && w_rd_beat[0]) || (w_count_next == '0)) begin
                    r_release <= 1'b0;
                end else if (w_full && (r_bursts == '0)) begin
                    r_release <= 1'b1;
                end
            end
            assign w_valid = !w_empty && ((r_bursts != '0) || w_full || r_release);
        end else begin : g_cut_through
            assign w_valid = !w_empty;
        end
    endgenerate

    assign slave_ready_o  = ~w_full;
    assign master_valid_o = w_valid;
    assign {master_id_o, master_user_o, master_data_o, master_resp_o, master_last_o} = w_rd_beat;
    assign count_o        = r_count;
    assign bursts_o       = r_bursts;
    assign almost_full_o  = (r_count >= CNT_WIDTH'(AFULL_THRESH));

endmodule
`default_nettype wire

// File: tb/tb_axi2mem_r_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi2mem_r_fifo
// Description : Directed bench for axi2mem_r_fifo, cut-through (index 0) and
//               store-and-forward (index 1) instances against a list model.
// Revision    : 1.0
// ============================================================================
module tb_axi2mem_r_fifo;

    typedef struct packed {
        logic [3:0]  id;
        logic [5:0]  user;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid [2];
    beat_t       s_beat  [2];
    logic        s_ready [2];
    logic        m_valid [2];
    logic [63:0] m_data  [2];
    logic [1:0]  m_resp  [2];
    logic [5:0]  m_user  [2];
    logic [3:0]  m_id    [2];
    logic        m_last  [2];
    logic        m_ready [2];
    logic [2:0]  count   [2];
    logic [2:0]  bursts  [2];
    logic        afull   [2];

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    axi2mem_r_fifo #(.STORE_FWD(0)) u_ct (
        .clk_i(clk), .rst_ni(rst_n),
        .slave_valid_i(s_valid[0]), .slave_data_i(s_beat[0].data), .slave_resp_i(s_beat[0].resp),
        .slave_user_i(s_beat[0].user), .slave_id_i(s_beat[0].id), .slave_last_i(s_beat[0].last),
        .slave_ready_o(s_ready[0]),
        .master_valid_o(m_valid[0]), .master_data_o(m_data[0]), .master_resp_o(m_resp[0]),
        .master_user_o(m_user[0]), .master_id_o(m_id[0]), .master_last_o(m_last[0]),
        .master_ready_i(m_ready[0]),
        .count_o(count[0]), .bursts_o(bursts[0]), .almost_full_o(afull[0])
    );

    axi2mem_r_fifo #(.STORE_FWD(1)) u_sf (
        .clk_i(clk), .rst_ni(rst_n),
        .slave_valid_i(s_valid[1]), .slave_data_i(s_beat[1].data), .slave_resp_i(s_beat[1].resp),
        .slave_user_i(s_beat[1].user), .slave_id_i(s_beat[1].id), .slave_last_i(s_beat[1].last),
        .slave_ready_o(s_ready[1]),
        .master_valid_o(m_valid[1]), .master_data_o(m_data[1]), .master_resp_o(m_resp[1]),
        .master_user_o(m_user[1]), .master_id_o(m_id[1]), .master_last_o(m_last[1]),
        .master_ready_i(m_ready[1]),
        .count_o(count[1]), .bursts_o(bursts[1]), .almost_full_o(afull[1])
    );

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: ordered list of stored beats per instance.
    beat_t mq   [2][4];
    int    mcnt [2];
    bit    mrel [2];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                mcnt[k] = 0;
                mrel[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int    nb;
                int    n;
                bit    ev;
                bit    push;
                bit    pop;
                bit    pop_last;
                beat_t act;
                nb = 0;
                for (int i = 0; i < mcnt[k]; i++) nb += int'(mq[k][i].last);
                ev = (mcnt[k] > 0) && (k == 0 || nb > 0 || mcnt[k] == 4 || mrel[k]);
                chk($sformatf("ready%0d", k), 80'(s_ready[k]), 80'(mcnt[k] < 4));
                chk($sformatf("valid%0d", k), 80'(m_valid[k]), 80'(ev));
                chk($sformatf("count%0d", k), 80'(count[k]), 80'(mcnt[k]));
                chk($sformatf("bursts%0d", k), 80'(bursts[k]), 80'(nb));
                chk($sformatf("afull%0d", k), 80'(afull[k]), 80'(mcnt[k] >= 3));
                if (ev) begin
                    act = {m_id[k], m_user[k], m_data[k], m_resp[k], m_last[k]};
                    chk($sformatf("payload%0d", k), 80'(act), 80'(mq[k][0]));
                end
                push     = s_valid[k] && (mcnt[k] < 4);
                pop      = ev && m_ready[k];
                pop_last = pop && mq[k][0].last;
                n = mcnt[k];
                if (k == 1) begin
                    if (pop_last || (n + int'(push) - int'(pop)) == 0) mrel[k] = 1'b0;
                    else if (n == 4 && nb == 0) mrel[k] = 1'b1;
                end
                if (pop) begin
                    for (int i = 0; i < 3; i++) mq[k][i] = mq[k][i+1];
                    n--;
                end
                if (push) begin
                    mq[k][n] = s_beat[k];
                    n++;
                end
                mcnt[k] = n;
            end
        end
    end

    function automatic beat_t mk(input logic [3:0] id, input logic [63:0] d, input logic last);
        beat_t b;
        b.id   = id;
        b.user = d[5:0] ^ 6'h2A;
        b.data = d;
        b.resp = d[1:0];
        b.last = last;
        return b;
    endfunction

    // Offer a beat for up to maxcyc cycles; valid is left high if not taken.
    task automatic push(input int k, input beat_t b, input int maxcyc, output bit ok);
        s_valid[k] = 1'b1;
        s_beat[k]  = b;
        ok = 1'b0;
        for (int c = 0; c < maxcyc && !ok; c++) begin
            @(negedge clk);
            ok = s_ready[k];
            @(posedge clk);
            #2;
        end
        if (ok) s_valid[k] = 1'b0;
    endtask

    task automatic push_must(input int k, input beat_t b);
        bit ok;
        push(k, b, 8, ok);
        chk($sformatf("push_accept%0d", k), 80'(ok), 80'(1));
        s_valid[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int c;
        m_ready[k] = 1'b1;
        c = 0;
        while (count[k] != 3'd0 && c < 30) begin
            @(posedge clk);
            #2;
            c++;
        end
        chk($sformatf("drain_done%0d", k), 80'(count[k]), 80'(0));
        m_ready[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = 1'b0;
            s_beat[k]  = '0;
            m_ready[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready", 80'(s_ready[0]), 80'(1));
        chk("rst_valid", 80'(m_valid[0]), 80'(0));
        chk("rst_data", 80'(m_data[0]), 80'(0));
        chk("rst_count", 80'(count[1]), 80'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Single beat
        push_must(0, mk(4'd3, 64'hA5, 1'b1));
        chk("t1_valid", 80'(m_valid[0]), 80'(1));
        chk("t1_id", 80'(m_id[0]), 80'(3));
        chk("t1_data", 80'(m_data[0]), 80'(64'hA5));
        chk("t1_count", 80'(count[0]), 80'(1));
        m_ready[0] = 1'b1;
        @(posedge clk);
        #2;
        m_ready[0] = 1'b0;
        chk("t1_count_after", 80'(count[0]), 80'(0));

        // Fill to full with downstream stalled; fifth beat held
        for (int i = 0; i < 4; i++) begin
            push_must(0, mk(4'(i), 64'h1000 + 64'(i), 1'b0));
            chk("t2_afull", 80'(afull[0]), 80'(i >= 2));
        end
        chk("t2_count", 80'(count[0]), 80'(4));
        chk("t2_ready", 80'(s_ready[0]), 80'(0));
        push(0, mk(4'd4, 64'h1004, 1'b1), 3, ok);
        chk("t2_fifth_held", 80'(ok), 80'(0));
        m_ready[0] = 1'b1;
        @(posedge clk);
        #2;
        m_ready[0] = 1'b0;
        push(0, mk(4'd4, 64'h1004, 1'b1), 3, ok);
        chk("t2_fifth_taken", 80'(ok), 80'(1));
        s_valid[0] = 1'b0;
        chk("t2_count_refill", 80'(count[0]), 80'(4));
        drain(0);

        // Streaming at one beat per cycle
        m_ready[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push(0, mk(4'(i), 64'hBEEF0000 + 64'(i * 7), i[1]), 4, ok);
            if (i > 0) chk("t3_count", 80'(count[0]), 80'(1));
        end
        s_valid[0] = 1'b0;
        drain(0);

        // Store-and-forward: three-beat burst
        m_ready[1] = 1'b1;
        push_must(1, mk(4'd5, 64'h20, 1'b0));
        chk("t4_valid_b1", 80'(m_valid[1]), 80'(0));
        push_must(1, mk(4'd5, 64'h21, 1'b0));
        chk("t4_valid_b2", 80'(m_valid[1]), 80'(0));
        push_must(1, mk(4'd5, 64'h22, 1'b1));
        chk("t4_valid_b3", 80'(m_valid[1]), 80'(1));
        chk("t4_bursts", 80'(bursts[1]), 80'(1));
        repeat (3) @(posedge clk);
        #2;
        chk("t4_bursts_after", 80'(bursts[1]), 80'(0));
        chk("t4_count_after", 80'(count[1]), 80'(0));
        m_ready[1] = 1'b0;

        // Store-and-forward: six-beat burst longer than the FIFO
        for (int i = 0; i < 4; i++) push_must(1, mk(4'd9, 64'h300 + 64'(i), 1'b0));
        chk("t5_full_bursts", 80'(bursts[1]), 80'(0));
        chk("t5_full_valid", 80'(m_valid[1]), 80'(1));
        m_ready[1] = 1'b1;
        push_must(1, mk(4'd9, 64'h304, 1'b0));
        push_must(1, mk(4'd9, 64'h305, 1'b1));
        drain(1);
        push_must(1, mk(4'd2, 64'h400, 1'b0));
        chk("t5_release_cleared", 80'(m_valid[1]), 80'(0));
        push_must(1, mk(4'd2, 64'h401, 1'b1));
        drain(1);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) push_must(0, mk(4'd6, 64'h500 + 64'(i), 1'(i == 1)));
        chk("t6_count_pre", 80'(count[0]), 80'(3));
        rst_n = 1'b0;
        #1;
        chk("t6_count", 80'(count[0]), 80'(0));
        chk("t6_valid", 80'(m_valid[0]), 80'(0));
        chk("t6_bursts", 80'(bursts[0]), 80'(0));
        chk("t6_ready", 80'(s_ready[0]), 80'(1));
        chk("t6_data", 80'(m_data[0]), 80'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
